// File: rtl/ram_port_arbiter_pkg.sv
// Shared defaults for the RAM port arbiter slice: RAM geometry, response
// buffer depth and the id-width helper used to size requester ids.
// No ports; imported by the interface, the arbiter and the top.
package ram_port_arbiter_pkg;

  localparam int DEF_NUM_REQ = 2;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 7;
  localparam int RSP_DEPTH   = 2;

  // ceil(log2(n)), but never below 1 so a lone requester still has an id bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = 0;
    for (int k = 0; k < 31; k++) begin
      if ((1 << w) < n) w = w + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Request/response bundle between client engines and the RAM port arbiter.
// Ports: none; signals are req_valid/we/addr/wdata/ready (packed per requester)
// and rsp_valid/id/rdata/ready. master = client side, slave = arbiter side.
interface ram_port_arbiter_if
  import ram_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int ID_W    = clog2_min1(NUM_REQ)
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready;

  logic                      rsp_valid;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_ready;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_rdata
  );

endinterface

// File: rtl/ram_port_arbiter_rr_arbiter.sv
// Round-robin pick: first asserted req at or after ptr, wrapping.
// Latency: purely combinational. Backpressure: none; no req -> gnt all zero.
// Ports: req (eligibility vector), ptr (search start) -> gnt (one-hot), gnt_idx, gnt_any.
module rr_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx,
  output logic               gnt_any
);

  logic [ID_W-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = '0;
    // Walk offsets 0..NUM_REQ-1 from the pointer; the first hit wins.
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!gnt_any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        gnt_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port registered-read RAM among NUM_REQ requesters, round-robin.
// Latency: grant is combinational; read data appears on rsp_* 2 cycles after accept.
// Backpressure: rsp_ready low fills a 2-entry buffer; reads then stall, writes still flow.
// Ports: clk, rst_n (async, active low); bus (slave side of ram_port_arbiter_if);
//        ram_we/ram_addr/ram_d to the RAM, ram_q from it (valid one cycle after a read).
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int ID_W    = clog2_min1(NUM_REQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  ram_port_arbiter_if.slave bus,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_d,
  input  logic [DATA_W-1:0] ram_q
);

  // Arbitration state
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    nxt_ptr;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_any;
  logic               accept;

  // Granted requester's fields and the values held when nobody is granted
  logic               g_we;
  logic [ADDR_W-1:0]  g_addr;
  logic [DATA_W-1:0]  g_d;
  logic [ADDR_W-1:0]  last_addr;
  logic [DATA_W-1:0]  last_d;

  // Read in flight to the RAM
  logic               inflight;
  logic [ID_W-1:0]    inflight_id;

  // Response buffer
  logic [DATA_W-1:0]  fifo_dat [RSP_DEPTH];
  logic [ID_W-1:0]    fifo_id  [RSP_DEPTH];
  logic               wr_ptr;
  logic               rd_ptr;
  logic [1:0]         count;
  logic [2:0]         occ;
  logic               read_space;
  logic               push;
  logic               pop;

  // A read needs a guaranteed slot: everything already accepted but not yet
  // consumed (buffered plus in flight) must leave room for one more.
  assign occ        = {1'b0, count} + {2'b00, inflight};
  assign read_space = (occ < 3'd2);

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = bus.req_valid[i] & (bus.req_we[i] | read_space);
    end
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req     (eligible),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // Grants are suppressed while reset is held so nothing transfers or writes.
  assign accept        = gnt_any & rst_n;
  assign bus.req_ready = gnt & {NUM_REQ{rst_n}};

  always_comb begin
    g_we   = 1'b0;
    g_addr = '0;
    g_d    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        g_we   = bus.req_we[i];
        g_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
        g_d    = bus.req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign nxt_ptr  = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);

  assign ram_we   = accept & g_we;
  assign ram_addr = gnt_any ? g_addr : last_addr;
  assign ram_d    = gnt_any ? g_d    : last_d;

  // Capture is keyed only on the in-flight flag, so a write granted in the
  // capture cycle cannot disturb the read data being pushed.
  assign push = inflight;
  assign pop  = bus.rsp_valid & bus.rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      last_addr   <= '0;
      last_d      <= '0;
      inflight    <= 1'b0;
      inflight_id <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
      for (int e = 0; e < RSP_DEPTH; e++) begin
        fifo_dat[e] <= '0;
        fifo_id[e]  <= '0;
      end
    end else begin
      if (accept) begin
        rr_ptr    <= nxt_ptr;
        last_addr <= g_addr;
        last_d    <= g_d;
      end
      inflight <= accept & ~g_we;
      if (accept && !g_we) inflight_id <= gnt_idx;

      if (push) begin
        fifo_dat[wr_ptr] <= ram_q;
        fifo_id[wr_ptr]  <= inflight_id;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;

      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign bus.rsp_valid = (count != 2'd0);
  assign bus.rsp_id    = fifo_id[rd_ptr];
  assign bus.rsp_rdata = fifo_dat[rd_ptr];

endmodule
